// File: rtl/sram_sp_masked_clr.sv
// ----------------------------------------------------------------------------
// sram_sp_masked_clr
//   Generic single-port (RW0) SRAM wrapper with per-lane write mask and a
//   hardware clear engine. After reset, or on a clr_req pulse, the whole array
//   is swept with CLR_VALUE, one entry per cycle. The port is blocked while
//   the sweep runs. Read data comes back with latency 1, or latency 2 when
//   OUT_REG is set. Between results, RW0_rdata holds the last read value.
//
// Ports
//   RW0_clk     in   clock, rising edge
//   RW0_rst_n   in   async active-low reset
//   RW0_en      in   request valid
//   RW0_wmode   in   1 = write, 0 = read
//   RW0_addr    in   entry address
//   RW0_wmask   in   lane i writes bits [i*MASK_GRAN +: MASK_GRAN]
//   RW0_wdata   in   write data
//   RW0_ready   out  request accepted when RW0_en & RW0_ready
//   RW0_rdata   out  read data (held between results)
//   RW0_rvalid  out  one-cycle pulse per completed read
//   clr_req     in   pulse: re-clear the whole array
//   clr_busy    out  clear sweep in progress
// ----------------------------------------------------------------------------
module sram_sp_masked_clr #(
    parameter int                    DATA_WIDTH = 42,
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DEPTH      = 8192,
    parameter int                    MASK_GRAN  = 7,
    parameter int                    MASK_WIDTH = 6,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                  RW0_clk,
    input  logic                  RW0_rst_n,
    input  logic                  RW0_en,
    input  logic                  RW0_wmode,
    input  logic [ADDR_WIDTH-1:0] RW0_addr,
    input  logic [MASK_WIDTH-1:0] RW0_wmask,
    input  logic [DATA_WIDTH-1:0] RW0_wdata,
    output logic                  RW0_ready,
    output logic [DATA_WIDTH-1:0] RW0_rdata,
    output logic                  RW0_rvalid,
    input  logic                  clr_req,
    output logic                  clr_busy
);

    localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Geometry checks: a bad configuration must not elaborate.
    generate
        if (DATA_WIDTH % MASK_GRAN != 0) begin : g_err_gran
            $error("sram_sp_masked_clr: DATA_WIDTH must be a multiple of MASK_GRAN");
        end
        if (MASK_WIDTH != DATA_WIDTH / MASK_GRAN) begin : g_err_mask
            $error("sram_sp_masked_clr: MASK_WIDTH must equal DATA_WIDTH/MASK_GRAN");
        end
        if (DEPTH < 1 || DEPTH > 2 ** ADDR_WIDTH) begin : g_err_depth
            $error("sram_sp_masked_clr: DEPTH must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_run;
    logic                  w_in_range;
    logic                  w_wr;
    logic                  w_rd;
    logic [IDX_W-1:0]      w_idx;

    logic                  r_vld_p1;
    logic [DATA_WIDTH-1:0] r_rdata_p1;

    assign w_run      = (r_state == ST_RUN);
    assign RW0_ready  = w_run;
    assign clr_busy   = ~w_run;
    // Only the low IDX_W bits select an entry; the range check masks aliases.
    assign w_in_range = ({1'b0, RW0_addr} < DEPTH_EXT);
    assign w_idx      = RW0_addr[IDX_W-1:0];
    assign w_wr       = RW0_en & w_run & RW0_wmode & w_in_range;
    assign w_rd       = RW0_en & w_run & ~RW0_wmode;

    // Sweep FSM: DEPTH cycles in CLEAR, one entry per cycle, then RUN.
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_ptr == LAST_PTR) begin
                        r_state <= ST_RUN;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                    end
                end
            endcase
        end
    end

    // Storage is never reset; the sweep is what defines its contents.
    always_ff @(posedge RW0_clk) begin
        if (!w_run) begin
            r_mem[r_ptr[IDX_W-1:0]] <= CLR_VALUE;
        end else if (w_wr) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (RW0_wmask[i]) begin
                    r_mem[w_idx][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // ---- stage p1: synchronous array read; out-of-range reads return zero ----
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            r_vld_p1   <= 1'b0;
            r_rdata_p1 <= '0;
        end else begin
            r_vld_p1 <= w_rd;
            if (w_rd) begin
                r_rdata_p1 <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    // ---- stage p2: optional output register ----
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_vld_p2;
            logic [DATA_WIDTH-1:0] r_rdata_p2;

            always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
                if (!RW0_rst_n) begin
                    r_vld_p2   <= 1'b0;
                    r_rdata_p2 <= '0;
                end else begin
                    r_vld_p2 <= r_vld_p1;
                    if (r_vld_p1) begin
                        r_rdata_p2 <= r_rdata_p1;
                    end
                end
            end

            assign RW0_rvalid = r_vld_p2;
            assign RW0_rdata  = r_rdata_p2;
        end else begin : g_no_out_reg
            assign RW0_rvalid = r_vld_p1;
            assign RW0_rdata  = r_rdata_p1;
        end
    endgenerate

endmodule
